// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The master drives operands and result acceptance; the slave is the adder pipeline.
interface addsub_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, overflow, carry
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, overflow, carry
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// registered slices, with optional signed saturation on the registered output.
module addsub_pipe #(
  parameter int WIDTH    = 64,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input logic          clk,
  input logic          rst_n,
  addsub_pipe_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic              adv_s;
  logic              last_vld_s;
  logic [STAGES-1:0] vld_r;
  logic [WIDTH-1:0]  raw_s;
  logic [WIDTH-1:0]  res_s;
  logic              a_msb_s;
  logic              bx_msb_s;
  logic              ovf_s;
  logic              carry_s;
  logic [WIDTH-1:0]  result_r;
  logic              overflow_r;
  logic              carry_r;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv_s         = !vld_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;
  assign bus.carry     = carry_r;

  // Stage k adds slice k. Its register keeps only the still-unused upper operand
  // bits (which include both sign bits) plus the low sum bits produced so far.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = WIDTH - k * SW;
    localparam int LW = (k + 1) * SW;

    logic [RW-1:0] op_a_s;
    logic [RW-1:0] op_bx_s;
    logic          op_c_s;
    logic          op_sub_s;
    logic [SW:0]   slice_s;
    logic [LW-1:0] sum_s;

    if (k == 0) begin : g_src
      assign op_a_s   = bus.a;
      assign op_bx_s  = bus.b ^ {WIDTH{bus.sub}};
      assign op_c_s   = bus.sub;
      assign op_sub_s = bus.sub;
      assign sum_s    = slice_s[SW-1:0];
    end else begin : g_src
      assign op_a_s   = g_stage[k-1].g_reg.a_r;
      assign op_bx_s  = g_stage[k-1].g_reg.bx_r;
      assign op_c_s   = g_stage[k-1].g_reg.c_r;
      assign op_sub_s = g_stage[k-1].g_reg.sub_r;
      assign sum_s    = {slice_s[SW-1:0], g_stage[k-1].g_reg.sum_r};
    end

    assign slice_s = {1'b0, op_a_s[SW-1:0]} + {1'b0, op_bx_s[SW-1:0]} + {{SW{1'b0}}, op_c_s};

    if (k < STAGES - 1) begin : g_reg
      logic [RW-SW-1:0] a_r;
      logic [RW-SW-1:0] bx_r;
      logic [LW-1:0]    sum_r;
      logic             c_r;
      logic             sub_r;

      // Skew register: partial sum, slice carry and remaining operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r   <= '0;
          bx_r  <= '0;
          sum_r <= '0;
          c_r   <= 1'b0;
          sub_r <= 1'b0;
        end else if (adv_s) begin
          a_r   <= op_a_s[RW-1:SW];
          bx_r  <= op_bx_s[RW-1:SW];
          sum_r <= sum_s;
          c_r   <= slice_s[SW];
          sub_r <= op_sub_s;
        end
      end
    end
  end

  if (STAGES == 1) begin : g_last_vld
    assign last_vld_s = bus.in_valid;
  end else begin : g_last_vld
    assign last_vld_s = vld_r[STAGES-2];
  end

  // Valid shift chain; a bubble enters stage 0 whenever in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else if (adv_s) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_r[k] <= vld_r[k-1];
      end
      vld_r[0] <= bus.in_valid;
    end
  end

  // Flags always describe the raw sum; only the data word is clamped.
  always_comb begin
    raw_s    = g_stage[STAGES-1].sum_s;
    a_msb_s  = g_stage[STAGES-1].op_a_s[SW-1];
    bx_msb_s = g_stage[STAGES-1].op_bx_s[SW-1];
    ovf_s    = (a_msb_s == bx_msb_s) && (raw_s[WIDTH-1] != a_msb_s);
    carry_s  = g_stage[STAGES-1].slice_s[SW] ^ g_stage[STAGES-1].op_sub_s;
    if ((SATURATE != 0) && ovf_s) begin
      if (a_msb_s) begin
        res_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      res_s = raw_s;
    end
  end

  // Output register only loads real beats, so idle cycles keep the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r   <= '0;
      overflow_r <= 1'b0;
      carry_r    <= 1'b0;
    end else if (adv_s && last_vld_s) begin
      result_r   <= res_s;
      overflow_r <= ovf_s;
      carry_r    <= carry_s;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: 64-bit wrap and saturate instances share stimulus,
// an 8-bit/4-stage saturating instance gets a dense operand sweep.
module tb_addsub_pipe;
  typedef struct {
    logic [63:0] rw;
    logic [63:0] rs;
    logic        o;
    logic        c;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q64[$];
  exp_t q8[$];

  logic [63:0] a64 = 64'd0, b64 = 64'd0;
  logic        sub64 = 1'b0, iv64 = 1'b0, ordy64 = 1'b1;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        sub8 = 1'b0, iv8 = 1'b0;

  addsub_pipe_if #(.WIDTH(64)) bw ();
  addsub_pipe_if #(.WIDTH(64)) bs ();
  addsub_pipe_if #(.WIDTH(8))  bn ();

  assign bw.a = a64;  assign bw.b = b64;  assign bw.sub = sub64;
  assign bw.in_valid = iv64;  assign bw.out_ready = ordy64;
  assign bs.a = a64;  assign bs.b = b64;  assign bs.sub = sub64;
  assign bs.in_valid = iv64;  assign bs.out_ready = ordy64;
  assign bn.a = a8;   assign bn.b = b8;   assign bn.sub = sub8;
  assign bn.in_valid = iv8;   assign bn.out_ready = 1'b1;

  addsub_pipe #(.WIDTH(64), .STAGES(2), .SATURATE(0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));
  addsub_pipe #(.WIDTH(64), .STAGES(2), .SATURATE(1)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bs));
  addsub_pipe #(.WIDTH(8),  .STAGES(4), .SATURATE(1)) u_nar  (.clk(clk), .rst_n(rst_n), .bus(bn));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: true signed/unsigned values in wide arithmetic, then range-checked.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
    exp_t e;
    logic [63:0] mask;
    logic [65:0] ua, ub, uv;
    logic signed [65:0] sa, sb, sv, maxv, minv, one_s;
    one_s = 66'sd1;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua = {2'b00, a & mask};
    ub = {2'b00, b & mask};
    uv = s ? (ua - ub) : (ua + ub);
    sa = $signed(ua);
    sb = $signed(ub);
    if (ua[w-1]) sa = sa - (one_s <<< w);
    if (ub[w-1]) sb = sb - (one_s <<< w);
    sv   = s ? (sa - sb) : (sa + sb);
    maxv = (one_s <<< (w - 1)) - one_s;
    minv = -(one_s <<< (w - 1));
    e.c  = s ? (ua < ub) : uv[w];
    e.o  = (sv > maxv) || (sv < minv);
    e.rw = uv[63:0] & mask;
    if (e.o) e.rs = (sv < 66'sd0) ? (minv[63:0] & mask) : (maxv[63:0] & mask);
    else     e.rs = e.rw;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic s, input bit lat);
    exp_t e;
    int guard;
    @(negedge clk);
    a64 = a; b64 = b; sub64 = s; iv64 = 1'b1;
    #1;
    guard = 0;
    while (!bw.in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("in_ready_wait64", {63'd0, bw.in_ready}, 64'd1);
    e = model(64, a, b, s);
    e.acc = cyc + 1;
    e.lat = lat;
    q64.push_back(e);
    @(posedge clk);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; iv8 = 1'b1;
    #1;
    e = model(8, {56'd0, a}, {56'd0, b}, s);
    e.acc = cyc + 1;
    e.lat = 1'b1;
    if (bn.in_ready) q8.push_back(e);
    else check("in_ready8", {63'd0, bn.in_ready}, 64'd1);
    @(posedge clk);
  endtask

  // Monitor for the 64-bit pair: reset values, stall behaviour, scoreboard pops.
  logic [63:0] held_r = 64'd0;
  bit          held_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      check("rst_out_valid", {63'd0, bw.out_valid}, 64'd0);
      check("rst_result", bw.result, 64'd0);
      check("rst_in_ready", {63'd0, bw.in_ready}, 64'd1);
      check("rst_sat_valid", {63'd0, bs.out_valid}, 64'd0);
      held_v = 1'b0;
    end else begin
      if (held_v && bw.out_valid) check("stall_hold", bw.result, held_r);
      if (bw.out_valid && !bw.out_ready) begin
        check("stall_in_ready", {63'd0, bw.in_ready}, 64'd0);
        held_r = bw.result;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      check("sat_valid_sync", {63'd0, bs.out_valid}, {63'd0, bw.out_valid});
      if (bw.out_valid && bw.out_ready) begin
        if (q64.size() == 0) begin
          check("stale_beat64", {63'd0, bw.out_valid}, 64'd0);
        end else begin
          e = q64.pop_front();
          check("wrap_result", bw.result, e.rw);
          check("wrap_overflow", {63'd0, bw.overflow}, {63'd0, e.o});
          check("wrap_carry", {63'd0, bw.carry}, {63'd0, e.c});
          check("sat_result", bs.result, e.rs);
          check("sat_overflow", {63'd0, bs.overflow}, {63'd0, e.o});
          check("sat_carry", {63'd0, bs.carry}, {63'd0, e.c});
          if (e.lat) check("latency64", 64'(cyc), 64'(e.acc + 1));
        end
      end
    end
  end

  // Monitor for the 8-bit, 4-stage instance.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bn.out_valid) begin
      if (q8.size() == 0) begin
        check("stale_beat8", {63'd0, bn.out_valid}, 64'd0);
      end else begin
        e = q8.pop_front();
        check("n8_result", {56'd0, bn.result}, e.rs);
        check("n8_overflow", {63'd0, bn.overflow}, {63'd0, e.o});
        check("n8_carry", {63'd0, bn.carry}, {63'd0, e.c});
        if (e.lat) check("latency8", 64'(cyc), 64'(e.acc + 3));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bset [16];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed 64-bit cases, out_ready held high so latency is exact.
    send64(64'd5, 64'd7, 1'b0, 1'b1);
    send64(64'd5, 64'd7, 1'b1, 1'b1);
    send64(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    send64(64'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send64(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    send64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send64({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(1)), 1'b1);
    end
    @(negedge clk);
    iv64 = 1'b0;
    repeat (3) @(negedge clk);

    // Six back-to-back beats with a three-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send64({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(1)), 1'b0);
        end
        @(negedge clk);
        iv64 = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        ordy64 = 1'b0;
        repeat (3) @(negedge clk);
        ordy64 = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    // Reset with two beats in flight: nothing may emerge afterwards.
    send64(64'h1111, 64'h2222, 1'b0, 1'b0);
    send64(64'h3333, 64'h1111, 1'b1, 1'b0);
    @(negedge clk);
    iv64   = 1'b0;
    ordy64 = 1'b0;
    rst_n  = 1'b0;
    q64.delete();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    ordy64 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("post_reset_valid", {63'd0, bw.out_valid}, 64'd0);
    end
    send64(64'd40, 64'd2, 1'b0, 1'b1);
    @(negedge clk);
    iv64 = 1'b0;

    // 8-bit sweep: every A, both operations, corner and random B values.
    bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h02; bset[3] = 8'h7E;
    bset[4] = 8'h7F; bset[5] = 8'h80; bset[6] = 8'h81; bset[7] = 8'hFE;
    bset[8] = 8'hFF;
    for (int i = 9; i < 16; i++) bset[i] = 8'($urandom());
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 16; j++) begin
        send8(8'(a), bset[j], 1'b0);
        send8(8'(a), bset[j], 1'b1);
      end
    end
    @(negedge clk);
    iv8 = 1'b0;

    for (int i = 0; i < 200 && (q64.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check("drain64", 64'(q64.size()), 64'd0);
    check("drain8", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
